// File: rtl/pipe_pkg.sv
// Shared pipeline constants: lane widths, control-vector bit map, stage sizes.
// Also defines the occupancy encoding used by the elastic stage register.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam int CTRL_BRANCH      = 0;
  localparam int CTRL_PC_LOAD     = 1;
  localparam int CTRL_PC_RESET    = 2;
  localparam int CTRL_REG_WRITE   = 3;
  localparam int CTRL_SEL_MUX2_LO = 4;
  localparam int CTRL_SEL_MUX2_HI = 5;
  localparam int CTRL_W_DEF       = 6;

  localparam int IF_ID_N_DATA  = 2;
  localparam int ID_EX_N_DATA  = 4;
  localparam int EX_MEM_N_DATA = 3;
  localparam int MEM_WB_N_DATA = 2;

  localparam int CNT_W_DEF = 16;

  // {skid_valid, main_valid}; 2'b10 cannot occur
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } stage_st_e;

  function automatic stage_st_e stage_state(logic main_v, logic skid_v);
    return stage_st_e'({skid_v, main_v});
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry elastic storage (main + skid) with registered in_ready.
// Flush drops both entries; data registers are only cleared by reset.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int N_DATA = 4,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [N_DATA*DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [N_DATA*DATA_W-1:0]   out_data
);

  logic                     main_v_q, main_v_d;
  logic                     skid_v_q, skid_v_d;
  logic [CTRL_W-1:0]        main_c_q, main_c_d;
  logic [CTRL_W-1:0]        skid_c_q, skid_c_d;
  logic [N_DATA*DATA_W-1:0] main_d_q, main_d_d;
  logic [N_DATA*DATA_W-1:0] skid_d_q, skid_d_d;
  logic                     in_xfer, out_xfer;
  stage_st_e                st;

  assign st       = stage_state(main_v_q, skid_v_q);
  assign in_xfer  = in_valid && !skid_v_q;
  assign out_xfer = main_v_q && out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_c_d = main_c_q;
    skid_c_d = skid_c_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      unique case (st)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_v_d = 1'b1;
            main_c_d = in_ctrl;
            main_d_d = in_data;
          end
        end
        ST_FULL: begin
          unique case ({in_xfer, out_xfer})
            2'b11: begin
              main_c_d = in_ctrl;
              main_d_d = in_data;
            end
            2'b10: begin
              skid_v_d = 1'b1;
              skid_c_d = in_ctrl;
              skid_d_d = in_data;
            end
            2'b01: main_v_d = 1'b0;
            default: ;
          endcase
        end
        ST_SKID: begin
          if (out_xfer) begin
            skid_v_d = 1'b0;
            main_c_d = skid_c_q;
            main_d_d = skid_d_q;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_c_q <= '0;
      skid_c_q <= '0;
      main_d_q <= '0;
      skid_d_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_c_q <= main_c_d;
      skid_c_q <= skid_c_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out_ctrl  = main_c_q;
  assign out_data  = main_d_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: skid buffer, bubble control zeroing, flush.
// Define PIPE_STAGE_STATS_EN to add saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int N_DATA = 4,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [N_DATA*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
`endif
);

  if (N_DATA < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: N_DATA, CTRL_W and CNT_W must be >= 1");
  end

  logic [CTRL_W-1:0] buf_ctrl;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .N_DATA (N_DATA),
    .CTRL_W (CTRL_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (buf_ctrl),
    .out_data  (out_data)
  );

  // A bubble must never carry reg_file_write or branch downstream
  assign out_ctrl = out_valid ? buf_ctrl : '0;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (!out_valid && bubble_q != '1)
      bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic
// checked against a capacity-2 FIFO model of the stage.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int N_DATA = 4;
  localparam int CTRL_W = 6;
  localparam int CNT_W  = 4;
  localparam int DW     = N_DATA * DATA_W;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready;
  logic              out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0]     in_data, out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .N_DATA (N_DATA),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DW-1:0]     d;
  } ent_t;

  ent_t q[$];
  bit   zero_data = 1'b1;
  bit   chk_en = 1'b0;
  int   m_stall = 0;
  int   m_bubble = 0;
  int   cmax = (1 << CNT_W) - 1;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, logic [DW-1:0] a, logic [DW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [DW-1:0] rep(logic [DATA_W-1:0] x);
    return {N_DATA{x}};
  endfunction

  // Stage = FIFO of depth 2; ready means fewer than two held entries
  task automatic model_edge();
    bit in_x, out_x;
    if (reset) begin
      q.delete();
      zero_data = 1'b1;
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (q.size() != 0 && !out_ready && m_stall < cmax) m_stall++;
      if (q.size() == 0 && m_bubble < cmax) m_bubble++;
      in_x  = in_valid && q.size() < 2;
      out_x = q.size() != 0 && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) begin
          q.push_back('{in_ctrl, in_data});
          zero_data = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
      chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
      if (q.size() != 0) begin
        chk("out_ctrl", DW'(out_ctrl), DW'(q[0].c));
        chk("out_data", out_data, q[0].d);
      end else begin
        chk("bubble_ctrl", DW'(out_ctrl), '0);
        if (zero_data) chk("reset_data", out_data, '0);
      end
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
      chk("bubble_cnt", DW'(bubble_cnt), DW'(m_bubble));
`endif
    end
  end

  task automatic cycle(input logic rs, input logic fl, input logic iv,
                       input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                       input logic ordy);
    reset     = rs;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    cycle(1, 0, 0, '0, '0, 1);
    chk_en = 1'b1;
    cycle(1, 0, 1, 6'h3f, rep(32'hdead), 1);
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_ready", DW'(in_ready), DW'(1));
    chk("rst_data", out_data, '0);

    // Streaming
    cycle(0, 0, 1, 6'h01, rep(32'h10), 1);
    chk("stream0", DW'(out_data[DATA_W-1:0]), DW'(32'h10));
    cycle(0, 0, 1, 6'h02, rep(32'h20), 1);
    chk("stream1", DW'(out_data[DATA_W-1:0]), DW'(32'h20));
    cycle(0, 0, 1, 6'h03, rep(32'h30), 1);
    chk("stream2", DW'(out_data[DATA_W-1:0]), DW'(32'h30));
    chk("stream_rdy", DW'(in_ready), DW'(1));
    cycle(0, 0, 0, '0, '0, 1);
    chk("stream_end", DW'(out_valid), DW'(0));

    // Stall into skid
    cycle(0, 0, 1, 6'h04, rep(32'hA), 1);
    cycle(0, 0, 1, 6'h05, rep(32'hB), 0);
    chk("skid_rdy", DW'(in_ready), DW'(0));
    chk("skid_holdA", DW'(out_data[DATA_W-1:0]), DW'(32'hA));
    cycle(0, 0, 1, 6'h06, rep(32'hC), 0);
    chk("skid_stall", DW'(out_data[DATA_W-1:0]), DW'(32'hA));
    cycle(0, 0, 0, '0, '0, 1);
    chk("skid_B", DW'(out_data[DATA_W-1:0]), DW'(32'hB));
    chk("skid_rdy1", DW'(in_ready), DW'(1));
    cycle(0, 0, 0, '0, '0, 1);

    // Flush while in skid
    cycle(0, 0, 1, 6'h07, rep(32'hA1), 0);
    cycle(0, 0, 1, 6'h08, rep(32'hB1), 0);
    cycle(0, 1, 1, 6'h09, rep(32'hC1), 0);
    chk("fl_valid", DW'(out_valid), DW'(0));
    chk("fl_ctrl", DW'(out_ctrl), DW'(0));
    chk("fl_ready", DW'(in_ready), DW'(1));
    cycle(0, 0, 0, '0, '0, 1);
    chk("fl_noC", DW'(out_valid), DW'(0));

    // Bubble zeroes control
    cycle(0, 0, 1, 6'b001001, rep(32'h55), 1);
    chk("bub_ctrl_in", DW'(out_ctrl), DW'(6'b001001));
    cycle(0, 0, 0, '0, '0, 1);
    chk("bub_ctrl0", DW'(out_ctrl), DW'(0));

    // Reset in SKID
    cycle(0, 0, 1, 6'h0a, rep(32'h77), 0);
    cycle(0, 0, 1, 6'h0b, rep(32'h88), 0);
    cycle(1, 0, 1, 6'h0c, rep(32'h99), 0);
    chk("rs_valid", DW'(out_valid), DW'(0));
    chk("rs_data", out_data, '0);
    chk("rs_ready", DW'(in_ready), DW'(1));
    cycle(0, 0, 0, '0, '0, 1);

`ifdef PIPE_STAGE_STATS_EN
    cycle(0, 0, 1, 6'h0d, rep(32'h42), 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, '0, 0);
    chk("stall_sat", DW'(stall_cnt), DW'(15));
    cycle(0, 1, 0, '0, '0, 0);
    chk("stall_flush", DW'(stall_cnt), DW'(15));
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] d;
      for (int k = 0; k < N_DATA; k++) d[k*DATA_W +: DATA_W] = $urandom;
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, CTRL_W'($urandom), d,
            $urandom_range(0, 2) != 0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
